// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: access sizes, FSM states and
// the alignment rule used to decide between a direct access and a byte split.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPLIT = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~addr_lo[0];
      default: return addr_lo == 2'b00;
    endcase
  endfunction

  // Size 11 is an alias for word on the memory side.
  function automatic logic [1:0] mode_of(input logic [1:0] size);
    return (size == 2'b11) ? SZ_WORD : size;
  endfunction

endpackage

// File: rtl/mem_access_unit_ext.sv
// Combinational load extender: sign- or zero-extends a right-justified byte or
// half to 32 bits; words (and the 11 alias) pass through unchanged.
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] val_i,
  output logic [31:0] ext_o
);

  always_comb begin
    ext_o = val_i;
    case (size_i)
      SZ_BYTE: ext_o = {{24{signed_i & val_i[7]}}, val_i[7:0]};
      SZ_HALF: ext_o = {{16{signed_i & val_i[15]}}, val_i[15:0]};
      default: ext_o = val_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the byte-lane data memory. Aligned accesses go straight
// through in one cycle; misaligned half/word accesses are replayed as byte accesses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              mem_str,
  output logic [1:0]        mem_mode,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is accepted in any IDLE cycle with req_valid high. While
  // stall is high the pipeline holds req_* unchanged; rsp_valid pulses exactly once
  // per accepted request, and req_* are ignored whenever the unit is not IDLE.

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d, last_q, last_d;
  logic              we_q, we_d, signed_q, signed_d;
  logic [1:0]        size_q, size_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d, asm_q, asm_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              stall_c, str_c, in_resp, aligned, ext_signed;
  logic [1:0]        ext_size;
  logic [DWIDTH-1:0] ext_val, ext_out, wdata_sh;

  assign in_resp    = (state_q == S_RESP);
  assign aligned    = is_aligned(req_size, req_addr[1:0]);
  assign wdata_sh   = wdata_q >> {k_q, 3'b000};

  // One extender serves both the direct path (IDLE) and the assembled result (RESP).
  assign ext_size   = in_resp ? size_q   : req_size;
  assign ext_signed = in_resp ? signed_q : req_signed;
  assign ext_val    = in_resp ? asm_q    : mem_dout;

  load_extend u_ext (
    .size_i   (ext_size),
    .signed_i (ext_signed),
    .val_i    (ext_val),
    .ext_o    (ext_out)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    last_d      = last_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    stall_c     = 1'b0;
    str_c       = 1'b0;
    mem_mode    = mode_of(req_size);
    mem_addr    = req_addr;
    mem_din     = req_wdata;
    case (state_q)
      S_IDLE: begin
        if (req_valid && aligned) begin
          str_c       = req_we;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = req_we ? '0 : ext_out;
        end else if (req_valid) begin
          stall_c  = 1'b1;
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          last_d   = (req_size == SZ_HALF) ? 2'd1 : 2'd3;
          k_d      = 2'd0;
          asm_d    = '0;
          state_d  = S_SPLIT;
        end
      end
      S_SPLIT: begin
        stall_c  = 1'b1;
        str_c    = we_q;
        mem_mode = SZ_BYTE;
        mem_addr = addr_q + AWIDTH'(k_q);
        mem_din  = {{(DWIDTH-8){1'b0}}, wdata_sh[7:0]};
        if (!we_q) asm_d[{k_q, 3'b000} +: 8] = mem_dout[7:0];
        if (k_q == last_q) state_d = S_RESP;
        else               k_d     = k_q + 2'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset must silence the strobe and stall at once, even mid-cycle.
  assign stall     = stall_c & ~clr;
  assign mem_str   = str_c & ~clr;
  assign rsp_valid = rsp_valid_q | in_resp;
  assign rsp_rdata = in_resp ? (we_q ? '0 : ext_out) : rsp_rdata_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      k_q         <= 2'd0;
      last_q      <= 2'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      last_q      <= last_d;
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule
